// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM state encodings and opcode legality check shared by ALU, controller and bench
package alu_pkg;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

  typedef enum logic [2:0] {
    S_LOAD_A  = 3'd0,
    S_LOAD_B  = 3'd1,
    S_LOAD_OP = 3'd2,
    S_EXEC    = 3'd3,
    S_SHOW    = 3'd4
  } state_e;

  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - button synchroniser, optional debounce (BTN_DEBOUNCE_EN), one-cycle press pulse
module btn_sync_edge #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic sync1_q, sync2_q;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
    end
  end

`ifdef BTN_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic          pulse_q;

  // Counter saturates at DEB_CYCLES so a held button fires only once.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else if (sync2_q) begin
      if (cnt_q != CW'(DEB_CYCLES)) cnt_q <= cnt_q + 1'b1;
      pulse_q <= (cnt_q == CW'(DEB_CYCLES - 1));
    end else begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end
  end

  assign o_pulse = pulse_q;
`else
  logic sync3_q;
  logic unused_deb;

  assign unused_deb = (DEB_CYCLES == 0);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) sync3_q <= 1'b0;
    else          sync3_q <= sync2_q;
  end

  assign o_pulse = sync2_q & ~sync3_q;
`endif

endmodule

// File: rtl/alu_input_ctrl.sv
// rtl/alu_input_ctrl.sv - switch/button sequencer latching A, B, OP for the ALU and registering its result (BTN_DEBOUNCE_EN)
module alu_input_ctrl
  import alu_pkg::*;
#(
  parameter int NB_DATA    = 4,
  parameter int NB_OP      = 6,
  parameter int NB_SW      = 8,
  parameter int DEB_CYCLES = 16
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic [NB_SW-1:0]   i_sw,
  input  logic [2:0]         i_btn,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_leds,
  output logic [2:0]         o_state,
  output logic               o_done,
  output logic               o_err
);

  logic [2:0] pulse;

  for (genvar g = 0; g < 3; g++) begin : g_btn
    btn_sync_edge #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
      .clk     (clk),
      .i_rst_n (i_rst_n),
      .i_btn   (i_btn[g]),
      .o_pulse (pulse[g])
    );
  end

  state_e             state_q;
  logic [NB_DATA-1:0] a_q, b_q, leds_q;
  logic [NB_OP-1:0]   op_q;
  logic               done_q, err_q;
  logic [NB_OP-1:0]   sw_op;
  logic               unused_sw;

  assign sw_op     = i_sw[NB_OP-1:0];
  assign unused_sw = ^i_sw[NB_SW-1:NB_OP];

  // Only the button the current state expects is served; any other press is an order error.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      leds_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_LOAD_A, S_SHOW: begin
          if (pulse[0]) begin
            a_q     <= i_sw[NB_DATA-1:0];
            state_q <= S_LOAD_B;
          end else if (pulse[1] || pulse[2]) begin
            err_q <= 1'b1;
          end
        end
        S_LOAD_B: begin
          if (pulse[1]) begin
            b_q     <= i_sw[NB_DATA-1:0];
            state_q <= S_LOAD_OP;
          end else if (pulse[0] || pulse[2]) begin
            err_q <= 1'b1;
          end
        end
        S_LOAD_OP: begin
          if (pulse[2]) begin
            if (is_legal_op(sw_op)) begin
              op_q    <= sw_op;
              state_q <= S_EXEC;
            end else begin
              err_q <= 1'b1;
            end
          end else if (pulse[0] || pulse[1]) begin
            err_q <= 1'b1;
          end
        end
        S_EXEC: begin
          leds_q  <= i_alu_result;
          done_q  <= 1'b1;
          state_q <= S_SHOW;
        end
        default: state_q <= S_LOAD_A;
      endcase
    end
  end

  assign o_alu_a  = a_q;
  assign o_alu_b  = b_q;
  assign o_alu_op = op_q;
  assign o_leds   = leds_q;
  assign o_state  = state_q;
  assign o_done   = done_q;
  assign o_err    = err_q;

endmodule

// File: tb/tb_alu_input_ctrl.sv
// tb/tb_alu_input_ctrl.sv - self-checking bench for alu_input_ctrl with a behavioural sequencer and ALU model
module tb_alu_input_ctrl;

`ifdef BTN_DEBOUNCE_EN
  localparam int DEB = 4;
  localparam int E   = 3;
  localparam int L   = DEB;
`else
  localparam int DEB = 16;
  localparam int E   = 2;
  localparam int L   = 1;
`endif
  localparam int HN = 24;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sw;
  logic [2:0] btn;
  logic [3:0] alu_result;
  logic [3:0] o_a, o_b, o_leds;
  logic [5:0] o_op;
  logic [2:0] o_state;
  logic       o_done, o_err;

  int n_checks = 0;
  int n_pass   = 0;
  int err_seen = 0;
  int done_seen = 0;

  always #5 clk = ~clk;

  alu_input_ctrl #(.NB_DATA(4), .NB_OP(6), .NB_SW(8), .DEB_CYCLES(DEB)) dut (
    .clk          (clk),
    .i_rst_n      (rst_n),
    .i_sw         (sw),
    .i_btn        (btn),
    .i_alu_result (alu_result),
    .o_alu_a      (o_a),
    .o_alu_b      (o_b),
    .o_alu_op     (o_op),
    .o_leds       (o_leds),
    .o_state      (o_state),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [5:0] op);
    case (op)
      6'b100000: return a + b;
      6'b100010: return a - b;
      6'b100100: return a & b;
      6'b100101: return a | b;
      6'b100110: return a ^ b;
      6'b100111: return ~(a | b);
      6'b000011: return 4'($signed(a) >>> b);
      6'b000010: return a >> b;
      default:   return 4'h0;
    endcase
  endfunction

  function automatic logic legal(input logic [5:0] op);
    logic [5:0] ops [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                            6'b100110, 6'b100111, 6'b000011, 6'b000010};
    foreach (ops[i]) if (ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  assign alu_result = alu_f(o_a, o_b, o_op);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: a press is accepted L consecutive raw samples after a low, E edges later.
  logic [2:0] h [0:HN-1];
  logic [3:0] m_a = 0, m_b = 0, m_leds = 0;
  logic [5:0] m_op = 6'b100000;
  logic [2:0] m_state = 0;
  logic       m_done = 0, m_err = 0;

  always @(posedge clk) begin : model
    logic [2:0] hn [0:HN-1];
    logic [2:0] p;
    logic       all1;
    if (!rst_n) begin
      for (int j = 0; j < HN; j++) h[j] <= 3'b000;
      m_a <= 0; m_b <= 0; m_leds <= 0; m_op <= 6'b100000;
      m_state <= 0; m_done <= 0; m_err <= 0;
    end else begin
      hn[0] = btn;
      for (int j = 1; j < HN; j++) hn[j] = h[j-1];
      for (int b = 0; b < 3; b++) begin
        all1 = 1'b1;
        for (int j = E; j < E + L; j++) all1 = all1 & hn[j][b];
        p[b] = all1 & ~hn[E+L][b];
      end
      for (int j = 0; j < HN; j++) h[j] <= hn[j];
      m_done <= 1'b0;
      m_err  <= 1'b0;
      case (m_state)
        3'd0, 3'd4: if (p[0]) begin m_a <= sw[3:0]; m_state <= 3'd1; end
                    else if (p[1] | p[2]) m_err <= 1'b1;
        3'd1: if (p[1]) begin m_b <= sw[3:0]; m_state <= 3'd2; end
              else if (p[0] | p[2]) m_err <= 1'b1;
        3'd2: if (p[2]) begin
                if (legal(sw[5:0])) begin m_op <= sw[5:0]; m_state <= 3'd3; end
                else m_err <= 1'b1;
              end else if (p[0] | p[1]) m_err <= 1'b1;
        3'd3: begin m_leds <= alu_f(m_a, m_b, m_op); m_done <= 1'b1; m_state <= 3'd4; end
        default: m_state <= 3'd0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (o_err)  err_seen++;
    if (o_done) done_seen++;
    check("cycle", {o_a, o_b, o_op, o_leds, o_state, o_done, o_err},
                   {m_a, m_b, m_op, m_leds, m_state, m_done, m_err});
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic press(input logic [2:0] b, input logic [7:0] s, input int hold);
    sw  = s;
    btn = b;
    cyc(hold);
    btn = 3'b000;
    cyc(L + 6);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic round(input logic [3:0] a, input logic [3:0] b, input logic [5:0] op);
    press(3'b001, {4'h0, a}, L + 1);
    press(3'b010, {4'h0, b}, L + 1);
    press(3'b100, {2'b00, op}, L + 1);
  endtask

  int e0, d0;

  initial begin
    rst_n = 1'b0; sw = 8'h00; btn = 3'b000;
    cyc(3);
    check("reset_state", o_state, 3'd0);
    check("reset_op", o_op, 6'b100000);
    rst_n = 1'b1;
    cyc(2);

    // Reset mid S_LOAD_OP
    press(3'b001, 8'h03, L + 1);
    press(3'b010, 8'h05, L + 1);
    check("pre_reset_state", o_state, 3'd2);
    rst_n = 1'b0;
    cyc(1);
    check("rst_mid_outs", {o_a, o_b, o_op, o_leds, o_state, o_done, o_err},
                          {4'h0, 4'h0, 6'b100000, 4'h0, 3'd0, 1'b0, 1'b0});
    rst_n = 1'b1;
    cyc(2);

    // Happy path
    d0 = done_seen;
    round(4'h3, 4'h5, 6'b100000);
    check("happy_leds", o_leds, 4'h8);
    check("happy_state", o_state, 3'd4);
    check("happy_done_cnt", done_seen - d0, 1);

    // Wrap-around
    d0 = done_seen;
    round(4'hF, 4'h1, 6'b100000);
    check("wrap_add_leds", o_leds, 4'h0);
    check("wrap_add_done", done_seen - d0, 1);
    round(4'h0, 4'h1, 6'b100010);
    check("wrap_sub_leds", o_leds, 4'hF);

    // Order and illegal opcode errors
    do_reset();
    e0 = err_seen;
    press(3'b010, 8'h09, L + 1);
    check("order_err", err_seen - e0, 1);
    check("order_b", o_b, 4'h0);
    check("order_state", o_state, 3'd0);
    press(3'b001, 8'h08, L + 1);
    press(3'b010, 8'h01, L + 1);
    e0 = err_seen;
    press(3'b100, 8'h3F, L + 1);
    check("illegal_err", err_seen - e0, 1);
    check("illegal_state", o_state, 3'd2);
    check("illegal_op", o_op, 6'b100000);
    press(3'b100, 8'h03, L + 1);
    check("sra_leds", o_leds, 4'hC);

    // Held and simultaneous buttons
    e0 = err_seen;
    press(3'b001, 8'h05, 50);
    check("held_state", o_state, 3'd1);
    check("held_a", o_a, 4'h5);
    check("held_noerr", err_seen - e0, 0);
    do_reset();
    e0 = err_seen;
    press(3'b011, 8'h07, L + 1);
    check("simul_a", o_a, 4'h7);
    check("simul_state", o_state, 3'd1);
    check("simul_noerr", err_seen - e0, 0);
    check("simul_b", o_b, 4'h0);

    // Press latency, and a too-short glitch when debouncing
    do_reset();
`ifdef BTN_DEBOUNCE_EN
    sw = 8'h06; btn = 3'b001;
    cyc(DEB - 1);
    btn = 3'b000;
    cyc(10);
    check("glitch_state", o_state, 3'd0);
    check("glitch_a", o_a, 4'h0);
`endif
    sw = 8'h0A; btn = 3'b001;
    cyc(E + L - 1);
    check("latency_early", o_state, 3'd0);
    cyc(1);
    check("latency_load", o_state, 3'd1);
    check("latency_a", o_a, 4'hA);
    btn = 3'b000;
    cyc(L + 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
